alu_mdu_sequencer: RTL

Parametrised successor to the combinational ALU operation decoder. Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code for single-cycle ops. Adds RV32M support: a multi-cycle multiply/divide unit (MDU) with an IDLE/BUSY/DONE state machine and a pipeline stall handshake. Sits in EX beside the ALU; the hazard unit ORs `stall_o` into its pipeline freeze.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/mdu_iter_core.sv | 102 ++++++++++
 rtl/alu_mdu_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder and RV32M multiply/divide sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_BLT  = 4'b1010,
    OP_BGE  = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_SLTU = 4'b1101,
    OP_BLTU = 4'b1110,
    OP_BGEU = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative RV32M datapath: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, with sign fix-up and the divide-by-zero / overflow early-outs.
module mdu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  mdu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_early,
  output logic             o_last,
  output logic [WIDTH-1:0] o_result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   r_hi, r_lo, r_md, r_result;
  logic [CNT_W-1:0]   r_cnt;
  mdu_op_e            r_op;
  logic               r_neg_res, r_rem_neg;

  logic               w_is_div, w_a_neg, w_b_neg, w_div_zero, w_div_ovf;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_early_res;
  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic [WIDTH-1:0]   w_hi_n, w_lo_n, w_quo_s, w_rem_s, w_final;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  always_comb begin
    w_is_div    = i_op[2];
    w_a_neg     = i_a[WIDTH-1] &&
                  (i_op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
    w_b_neg     = i_b[WIDTH-1] && (i_op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM});
    w_a_mag     = w_a_neg ? -i_a : i_a;
    w_b_mag     = w_b_neg ? -i_b : i_b;
    w_div_zero  = w_is_div && (i_b == '0);
    w_div_ovf   = (i_op inside {MDU_DIV, MDU_REM}) && (i_a == MIN_NEG) && (i_b == '1);
    o_early     = w_div_zero || w_div_ovf;
    // i_op[1] selects the remainder form for the divide ops
    if (w_div_zero) w_early_res = i_op[1] ? i_a : '1;
    else            w_early_res = i_op[1] ? '0 : i_a;
  end

  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : '0);
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_md};
    if (r_op[2]) begin
      w_hi_n = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end
    w_prod   = {w_hi_n, w_lo_n};
    w_prod_s = r_neg_res ? -w_prod : w_prod;
    w_quo_s  = r_neg_res ? -w_lo_n : w_lo_n;
    w_rem_s  = r_rem_neg ? -w_hi_n : w_hi_n;
    case (r_op)
      MDU_MUL:              w_final = w_prod_s[WIDTH-1:0];
      MDU_DIV, MDU_DIVU:    w_final = w_quo_s;
      MDU_REM, MDU_REMU:    w_final = w_rem_s;
      default:              w_final = w_prod_s[2*WIDTH-1:WIDTH];
    endcase
  end

  assign o_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign o_result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_md      <= '0;
      r_cnt     <= '0;
      r_op      <= MDU_MUL;
      r_neg_res <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
    end else if (i_start) begin
      r_hi      <= '0;
      r_lo      <= w_is_div ? w_a_mag : w_b_mag;
      r_md      <= w_is_div ? w_b_mag : w_a_mag;
      r_cnt     <= '0;
      r_op      <= i_op;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      if (o_early) r_result <= w_early_res;
    end else if (i_step) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_last) r_result <= w_final;
    end
  end

endmodule

// File: rtl/alu_mdu_sequencer.sv
// ALU operation decoder with optional RV32M multi-cycle MDU and stall handshake.
// Define ALU_MDU_EN to build the MDU; otherwise M-ops raise illegal_o.
module alu_mdu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             kill_i,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             is_rtype_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [3:0]       Operation,
  output logic             stall_o,
  output logic             mdu_done_o,
  output logic             mdu_sel_o,
  output logic [WIDTH-1:0] mdu_result_o,
  output logic             illegal_o
);

  logic    w_mop;
  alu_op_e w_op;

  assign w_mop = valid_i && is_rtype_i && (ALUOp == ALUOP_RTYPE) && (Funct7 == F7_MULDIV);

  always_comb begin
    w_op = OP_ADD;
    case (ALUOp)
      ALUOP_RTYPE: begin
        if (!w_mop) begin
          case (Funct3)
            3'b000:  w_op = (Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  w_op = OP_SLL;
            3'b010:  w_op = OP_SLT;
            3'b011:  w_op = OP_SLTU;
            3'b100:  w_op = OP_XOR;
            3'b101:  w_op = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end
      end
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_op = OP_ADD;
        endcase
      end
      default: w_op = OP_ADD;
    endcase
  end

  assign Operation = w_op;

`ifdef ALU_MDU_EN
  mdu_state_e       r_state, w_state_d;
  logic             w_start, w_step, w_early, w_last;
  logic [WIDTH-1:0] w_result;

  assign w_start = (r_state == ST_IDLE) && w_mop && !kill_i;
  assign w_step  = (r_state == ST_BUSY) && !kill_i;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_d = w_early ? ST_DONE : ST_BUSY;
      ST_BUSY: begin
        if (kill_i)      w_state_d = ST_IDLE;
        else if (w_last) w_state_d = ST_DONE;
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_d;
  end

  mdu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_op     (mdu_op_e'(Funct3)),
    .i_a      (src_a_i),
    .i_b      (src_b_i),
    .o_early  (w_early),
    .o_last   (w_last),
    .o_result (w_result)
  );

  assign stall_o      = w_mop && (r_state != ST_DONE);
  assign mdu_done_o   = (r_state == ST_DONE);
  assign mdu_sel_o    = (r_state == ST_DONE);
  assign mdu_result_o = w_result;
  assign illegal_o    = 1'b0;
`else
  logic             w_unused;
  logic [CNT_W-1:0] w_unused_cnt;

  assign w_unused     = ^{clk, rst_n, kill_i, src_a_i, src_b_i};
  assign w_unused_cnt = '0;
  assign stall_o      = 1'b0;
  assign mdu_done_o   = 1'b0;
  assign mdu_sel_o    = 1'b0;
  assign mdu_result_o = '0;
  assign illegal_o    = w_mop;
`endif

endmodule
